// File: rtl/deser_serial.sv
// Serial-to-parallel receiver for the 40-bit link.
// Bits arrive LSB first on each bit strobe. A frame starts with a start pulse.
// The rebuilt word is held in a valid/ready output register.
module deser_serial #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned IDX_W = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_bit_en,
  input  logic             i_sin,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_data,
  output logic             o_data_valid,
  input  logic             i_data_ready,
  output logic             o_frame_err,
  output logic             o_overrun
);

  typedef enum logic [0:0] {StIdle, StRecv} state_t;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WIDTH - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_data;
  logic             r_data_valid;
  logic             r_frame_err;
  logic             r_overrun;
  logic             r_busy;

  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_first;
  logic             w_accept;

  // Word as it stands with the current serial bit merged in at the current index.
  always_comb begin
    w_word        = r_shreg;
    w_word[r_idx] = i_sin;
    w_first       = {{(WIDTH-1){1'b0}}, i_sin};
    w_accept      = r_data_valid & i_data_ready;
  end

  // Receive FSM, shift register and output register; all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_shreg      <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      // Handshake clear; a word completing this edge overrides it below.
      if (w_accept) r_data_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state <= StRecv;
            r_busy  <= 1'b1;
            r_shreg <= i_bit_en ? w_first : '0;
            r_idx   <= i_bit_en ? IDX_W'(1) : '0;
          end
        end
        StRecv: begin
          if (i_start) begin
            // Start always wins, even against the final bit of a frame.
            r_frame_err <= 1'b1;
            r_shreg     <= i_bit_en ? w_first : '0;
            r_idx       <= i_bit_en ? IDX_W'(1) : '0;
          end else if (i_bit_en) begin
            r_shreg <= w_word;
            if (r_idx == LastIdx) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
              r_idx   <= '0;
              if (!r_data_valid || i_data_ready) begin
                r_data       <= w_word;
                r_data_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign o_idx        = r_idx;
  assign o_busy       = r_busy;
  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_deser_serial.sv
// Scoreboard bench for deser_serial: driver updates a bit-list model and pushes
// expected words; a negedge monitor pops on each handshake and checks status.
module tb_deser_serial;
  localparam int W = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b0, start = 1'b0, bit_en = 1'b0, sin = 1'b0, ready = 1'b0;
  logic [5:0]    idx;
  logic          busy, dvalid, ferr, ovr;
  logic [W-1:0]  data;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // Reference model state
  bit           m_bits[$];
  bit           m_busy, m_valid, m_ferr, m_ovr;
  logic [W-1:0] exp_q[$];

  deser_serial #(.WIDTH(40), .IDX_W(6)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_bit_en(bit_en), .i_sin(sin),
    .o_idx(idx), .o_busy(busy), .o_data(data), .o_data_valid(dvalid),
    .i_data_ready(ready), .o_frame_err(ferr), .o_overrun(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model one clock edge from the inputs that the DUT sees at that edge.
  task automatic model_edge(input bit r, input bit s, input bit be, input bit d, input bit rd);
    bit accept, new_word;
    logic [W-1:0] word;
    if (r) begin
      m_bits.delete(); m_busy = 0; m_valid = 0; m_ferr = 0; m_ovr = 0; exp_q.delete();
      return;
    end
    m_ferr = 0; accept = m_valid && rd; new_word = 0;
    if (s) begin
      if (m_busy) m_ferr = 1;
      m_busy = 1; m_bits.delete();
      if (be) m_bits.push_back(d);
    end else if (m_busy && be) begin
      m_bits.push_back(d);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) word[i] = m_bits[i];
        m_bits.delete(); m_busy = 0;
        if (!m_valid || rd) begin exp_q.push_back(word); new_word = 1; end
        else m_ovr = 1;
      end
    end
    m_valid = new_word ? 1'b1 : (accept ? 1'b0 : m_valid);
  endtask

  task automatic cyc(input bit s, input bit be, input bit d, input bit rd, input bit r = 0);
    reset = r; start = s; bit_en = be; sin = d; ready = rd;
    @(posedge clk);
    model_edge(r, s, be, d, rd);
    #1;
  endtask

  task automatic frame(input logic [W-1:0] w, input int gap, input bit rd);
    cyc(1, 1, w[0], rd);
    for (int i = 1; i < W; i++) begin
      for (int g = 1; g < gap; g++) cyc(0, 0, 1'($urandom), rd);
      cyc(0, 1, w[i], rd);
    end
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) cyc(0, 0, 1'($urandom), rd);
  endtask

  // Monitor: status every cycle, pop and compare on each handshake.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("data_valid", 64'(dvalid), 64'(m_valid));
        chk("idx", 64'(idx), 64'(m_bits.size()));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("frame_err", 64'(ferr), 64'(m_ferr));
        chk("overrun", 64'(ovr), 64'(m_ovr));
        if (dvalid && ready && !reset) begin
          if (exp_q.size() == 0) chk("unexpected_word", 64'(data), 64'hx);
          else begin e = exp_q.pop_front(); chk("word", 64'(data), 64'(e)); end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] rw;
    // 1: reset values then a basic frame
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    mon_en = 1'b1;
    chk("reset_data", 64'(data), 64'h0);
    frame(40'hA5_5A3C_C3F0, 1, 1);
    idle(3, 1);
    chk("t1_data", 64'(data), 64'hA5_5A3C_C3F0);
    // 2: overrun with ready low
    frame(40'h00_0000_0001, 1, 0);
    frame(40'hFF_FFFF_FFFF, 1, 0);
    idle(3, 0);
    chk("t2_data_held", 64'(data), 64'h1);
    chk("t2_overrun", 64'(ovr), 64'h1);
    idle(3, 1);
    chk("t2_overrun_sticky", 64'(ovr), 64'h1);
    // 3: start at idx=17, then a full frame
    cyc(1, 1, 1, 1);
    for (int i = 1; i < 17; i++) cyc(0, 1, 1'($urandom), 1);
    chk("t3_idx17", 64'(idx), 64'd17);
    frame(40'h12_3456_789A, 1, 1);
    idle(2, 1);
    chk("t3_data", 64'(data), 64'h12_3456_789A);
    // 4: strobe every 3rd cycle, random word
    rw = {8'($urandom), 32'($urandom)};
    frame(rw, 3, 1);
    idle(2, 1);
    chk("t4_data", 64'(data), 64'(rw));
    // start against the final bit: abort, no word
    cyc(1, 1, 0, 1);
    for (int i = 1; i < W - 1; i++) cyc(0, 1, 1'($urandom), 1);
    cyc(1, 1, 1, 1);
    idle(2, 1);
    // 5: reset at idx=25
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 1, 0);
    for (int i = 1; i < 25; i++) cyc(0, 1, 1'($urandom), 0);
    cyc(0, 1, 1, 0, 1);
    frame(40'hDE_ADBE_EF01, 1, 1);
    idle(2, 1);
    chk("t5_data", 64'(data), 64'hDE_ADBE_EF01);
    chk("t5_overrun", 64'(ovr), 64'h0);
    // 6: three back-to-back frames
    for (int k = 0; k < 3; k++) frame({8'($urandom), 32'($urandom)}, 1, 1);
    idle(2, 1);
    // random traffic: random ready, gaps, occasional aborts
    for (int n = 0; n < 400 * W; n++)
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
          ($urandom_range(0, 2) != 0));
    idle(4, 1);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
